// File: rtl/flag_basis_seq.sv
// flag_basis_seq
// Sequences one basis-index amplitude extraction against the flag register
// block. It loads the flag vector and walks every column. Where the
// left-corner flag is set, it requests a Q x ROW multiply. It rotates the flag
// vector after each column. At the end it reports whether every selected flag
// has been cleared.
module flag_basis_seq #(
  parameter int num_qubit = 4
) (
  input  logic                           clk,
  input  logic                           rst_new,
  input  logic                           start,
  input  logic                           sel2,
  input  logic [0:num_qubit-1]           flag_basis_pos,
  input  logic [0:num_qubit-1]           flag_basis_pos2,
  input  logic                           mult_ack,
  output logic                           ld_flag_pos,
  output logic                           ld_flag_pos2,
  output logic [1:0]                     load_update_flag,
  output logic                           mult_req,
  output logic [$clog2(num_qubit)-1:0]   mult_row,
  output logic [$clog2(num_qubit+1)-1:0] mult_count,
  output logic                           busy,
  output logic                           done,
  output logic                           basis_ok
);

  localparam int ROW_W = $clog2(num_qubit);
  localparam int CNT_W = $clog2(num_qubit + 1);
  localparam logic [ROW_W-1:0] LAST_COL = ROW_W'(num_qubit - 1);

  localparam logic [1:0] LUF_LOAD   = 2'd0;
  localparam logic [1:0] LUF_XOR    = 2'd1;
  localparam logic [1:0] LUF_ROTATE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_MULT,
    S_ROTATE,
    S_FINISH
  } state_t;

  state_t               state_q;
  logic                 sel_q;
  logic [ROW_W-1:0]     col_cnt_q;
  logic [ROW_W-1:0]     col_cnt_d;
  logic [CNT_W-1:0]     mult_count_q;
  logic [CNT_W-1:0]     mult_count_d;
  logic                 mult_req_q;
  logic [ROW_W-1:0]     mult_row_q;
  logic                 done_q;
  logic                 basis_ok_q;

  logic [0:num_qubit-1] sel_flags;
  logic                 ld_any;
  logic [1:0]           luf;

  // Flag vector belonging to the set chosen when the extraction started.
  assign sel_flags    = sel_q ? flag_basis_pos2 : flag_basis_pos;
  assign col_cnt_d    = col_cnt_q + ROW_W'(1);
  assign mult_count_d = mult_count_q + CNT_W'(1);

  // Control FSM. It walks LOAD, then CHECK/[MULT]/ROTATE once per column,
  // then FINISH.
  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      col_cnt_q    <= '0;
      mult_count_q <= '0;
      mult_req_q   <= 1'b0;
      mult_row_q   <= '0;
      done_q       <= 1'b0;
      basis_ok_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sel_q        <= sel2;
            col_cnt_q    <= '0;
            mult_count_q <= '0;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A stale result from the previous extraction is dropped here.
          basis_ok_q <= 1'b0;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          if (sel_flags[0]) begin
            mult_req_q <= 1'b1;
            mult_row_q <= col_cnt_q;
            state_q    <= S_MULT;
          end else begin
            state_q <= S_ROTATE;
          end
        end
        S_MULT: begin
          if (mult_ack) begin
            mult_req_q   <= 1'b0;
            mult_count_q <= mult_count_d;
            state_q      <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          col_cnt_q <= col_cnt_d;
          state_q   <= (col_cnt_q == LAST_COL) ? S_FINISH : S_CHECK;
        end
        S_FINISH: begin
          // After num_qubit rotates the vector is back in its original
          // alignment, so a plain NOR gives reachability.
          basis_ok_q <= ~|sel_flags;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flag-block strobe decode. The XOR update is Mealy on mult_ack so that it
  // lands in the same cycle as valid literals_out.
  always_comb begin
    ld_any = 1'b0;
    luf    = LUF_LOAD;
    case (state_q)
      S_LOAD: begin
        ld_any = 1'b1;
        luf    = LUF_LOAD;
      end
      S_ROTATE: begin
        ld_any = 1'b1;
        luf    = LUF_ROTATE;
      end
      S_MULT: begin
        if (mult_ack) begin
          ld_any = 1'b1;
          luf    = LUF_XOR;
        end
      end
      default: begin
        ld_any = 1'b0;
        luf    = LUF_LOAD;
      end
    endcase
  end

  assign ld_flag_pos      = ld_any & ~sel_q;
  assign ld_flag_pos2     = ld_any & sel_q;
  assign load_update_flag = luf;
  assign mult_req         = mult_req_q;
  assign mult_row         = mult_row_q;
  assign mult_count       = mult_count_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign basis_ok         = basis_ok_q;

endmodule

// File: doc/flag_basis_seq.md
Name: flag_basis_seq

Overview:
- Sequencer directly upstream of the flag_basis register block. Drives its ld_flag_pos / ld_flag_pos2 / load_update_flag controls and consumes its flag_basis_pos / flag_basis_pos2 outputs.
- For one basis-index amplitude extraction, it does three things:
  - loads the flag vector;
  - walks all num_qubit columns, requesting a Q x ROW multiply wherever the left-corner flag is set and rotating after each column;
  - reports whether the basis index is reachable (all flags cleared).
- Sits between the amplitude-extraction controller (start/done) and the row-multiply unit (req/ack).

Parameters:
num_qubit, 4, number of qubits; also the number of columns walked and the flag vector length.

Ports:
clk  input  1  clock
rst_new  input  1  asynchronous active-high reset
start  input  1  begin one extraction; honoured only in IDLE
sel2  input  1  0 = drive/observe flag_basis_pos, 1 = drive/observe flag_basis_pos2; captured at start
flag_basis_pos  input  1 x [0:num_qubit-1]  flag vector from the flag register block
flag_basis_pos2  input  1 x [0:num_qubit-1]  second flag vector from the flag register block
mult_ack  input  1  row-multiply unit done; literals_out is valid in this same cycle
ld_flag_pos  output  1  load strobe to the flag block (set 1)
ld_flag_pos2  output  1  load strobe to the flag block (set 2)
load_update_flag  output  2  0 = load, 1 = XOR update, 2 = rotate left
mult_req  output  1  request Q x ROW multiply
mult_row  output  $clog2(num_qubit)  stabilizer row index = current column
mult_count  output  $clog2(num_qubit+1)  number of multiplies issued in the current extraction
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
basis_ok  output  1  1 = all selected flags zero at finish

Behaviour:
- Reset (async, any state): state = IDLE. ld_flag_pos, ld_flag_pos2, mult_req, done, basis_ok, busy, mult_count, col_cnt, load_update_flag and mult_row all = 0.
- Strobe routing: exactly one of ld_flag_pos / ld_flag_pos2 is ever asserted, chosen by the captured sel_q. The unselected strobe is always 0.
- IDLE:
  - All strobes are 0.
  - start=1 at a clock edge: capture sel_q = sel2, clear col_cnt and mult_count, go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): selected ld = 1, load_update_flag = 0. Go to CHECK.
- CHECK (1 cycle):
  - Inspect selected flag[0].
  - If 1: go to MULT and register mult_req = 1, mult_row = col_cnt.
  - If 0: go to ROTATE.
- MULT:
  - mult_req is held at 1 until mult_ack.
  - In the mult_ack cycle, the block combinationally (Mealy) asserts selected ld = 1 and load_update_flag = 1, so the flag XOR coincides with valid literals_out.
  - At that edge: mult_req goes to 0, mult_count increments, go to ROTATE.
  - mult_ack outside MULT is ignored.
- ROTATE (1 cycle):
  - Selected ld = 1, load_update_flag = 2.
  - col_cnt increments.
  - If col_cnt == num_qubit-1 before the increment, go to FINISH; otherwise go to CHECK.
- FINISH (1 cycle): no strobes. At the exiting edge:
  - basis_ok = NOR of the selected flag vector;
  - done = 1 (registered);
  - go to IDLE.
- done clears after one cycle. basis_ok holds until the next LOAD edge, where it is cleared.
- load_update_flag = 0 whenever no strobe is asserted. The value 3 is never driven.
- Latency:
  - Start edge = edge 0. Column i CHECK ends at edge 2+2i+m, where m = cycles spent in MULT so far. The last ROTATE ends at edge 2N+1+m.
  - done is high after edge 2N+2+m. For N=4 with no multiplies, that is after edge 10.
  - Each multiply with an immediate ack adds 1 cycle.
- Flag realignment: after exactly num_qubit rotates, the flag vector is back in its original alignment.
- Reset mid-operation: strobes and mult_req drop immediately (asynchronously). A pending ack is then ignored.
- start together with reset: reset wins.

Test Plan:
1. N=4, sel2=0, load flags 0000 (the bench models the flag block) -> 4 CHECK/ROTATE pairs, mult_req never high; done after edge 10; basis_ok=1, mult_count=0; ld_flag_pos2 never high.
2. Flags 1010, ack returned the same cycle as req, literals clear flag[0] -> mult_req at columns 0 and 2, mult_row = 0 then 2; mult_count=2; done after edge 12; basis_ok=1.
3. Flags 0100, ack delayed 5 cycles, XOR leaves one flag set -> mult_req held high 5 cycles; update strobe (ld=1, load_update_flag=1) exactly in the ack cycle; basis_ok=0.
4. sel2=1 -> only ld_flag_pos2 toggles; start pulses during busy are ignored; stray mult_ack in CHECK is ignored.
5. rst_new asserted during MULT -> outputs 0 immediately, busy=0; a subsequent start performs a clean extraction with mult_count restarting from 0.
6. Back-to-back: start high in the done cycle -> new LOAD next cycle; basis_ok cleared at that LOAD edge.
